// File: rtl/multicycle_control_pkg.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control_pkg
// Brief    : Shared definitions for the multi-cycle RV32I control unit: state
//            encodings, opcode[6:2] class codes, ALU/PC/writeback selectors
//            and the opcode legality helper.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package multicycle_control_pkg;

    // Sequencer states; the numeric values are visible on the debug port.
    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_MEM    = 3'd4,
        ST_WB     = 3'd5,
        ST_HALT   = 3'd6
    } state_e;

    // Instruction classes, encoded as opcode[6:2].
    localparam logic [4:0] OP_LOAD   = 5'b00000;
    localparam logic [4:0] OP_IMMOP  = 5'b00100;
    localparam logic [4:0] OP_AUIPC  = 5'b00101;
    localparam logic [4:0] OP_STORE  = 5'b01000;
    localparam logic [4:0] OP_REG    = 5'b01100;
    localparam logic [4:0] OP_LUI    = 5'b01101;
    localparam logic [4:0] OP_BRANCH = 5'b11000;
    localparam logic [4:0] OP_JALR   = 5'b11001;
    localparam logic [4:0] OP_JAL    = 5'b11011;

    // ALU operation classes.
    localparam logic [1:0] ALUOP_ADD    = 2'b00;
    localparam logic [1:0] ALUOP_BRANCH = 2'b01;
    localparam logic [1:0] ALUOP_RFUNCT = 2'b10;
    localparam logic [1:0] ALUOP_IFUNCT = 2'b11;

    // PC source selection.
    localparam logic [1:0] PC_SRC_PLUS4  = 2'd0;
    localparam logic [1:0] PC_SRC_TARGET = 2'd1;
    localparam logic [1:0] PC_SRC_JALR   = 2'd2;

    // Register-file writeback source selection.
    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC4 = 2'd2;
    localparam logic [1:0] WB_SEL_IMM = 2'd3;

    // A legal opcode is a 32-bit encoding (low bits 11) of a supported class.
    function automatic logic is_legal_op(input logic [6:0] opc);
        logic known;
        case (opc[6:2])
            OP_LOAD, OP_IMMOP, OP_AUIPC, OP_STORE, OP_REG,
            OP_LUI, OP_BRANCH, OP_JALR, OP_JAL: known = 1'b1;
            default:                            known = 1'b0;
        endcase
        return known && (opc[1:0] == 2'b11);
    endfunction

endpackage

`default_nettype wire

// File: rtl/multicycle_control_mem_wait_timer.sv
//------------------------------------------------------------------------------
// Module   : mem_wait_timer
// Brief    : Counts cycles spent waiting on the memory handshake and flags
//            expiry on the wait cycle that brings the count to MEM_TIMEOUT.
//            MEM_TIMEOUT = 0 disables expiry.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_WIDTH   = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic clear_i,
    input  logic wait_i,
    output logic expired_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Clear on any state change, otherwise advance once per wait cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (wait_i) begin
            cnt_d = cnt_q + CNT_WIDTH'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // Expiry only on a wait cycle, so a same-cycle mem_ready always wins.
    generate
        if (MEM_TIMEOUT > 0) begin : g_timeout
            localparam logic [CNT_WIDTH-1:0] LIMIT_M1 = CNT_WIDTH'(MEM_TIMEOUT - 1);
            assign expired_o = wait_i && (cnt_q == LIMIT_M1);
        end else begin : g_no_timeout
            assign expired_o = 1'b0;
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/multicycle_control.sv
//------------------------------------------------------------------------------
// Module   : multicycle_control
// Brief    : Multi-cycle RV32I control FSM. Sequences each instruction through
//            IDLE/FETCH/DECODE/EXEC/MEM/WB, drives datapath strobes and a
//            req/ready memory handshake guarded by a wait timer.
//            Build option: CTRL_ILLEGAL_TRAP_EN - trap illegal opcodes to HALT
//            and raise illegal_insn; otherwise they execute as a NOP.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int OPCODE_WIDTH = 7,
    parameter int ALUOP_WIDTH  = 2,
    parameter int MEM_TIMEOUT  = 16,
    parameter int CNT_WIDTH    = 5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [OPCODE_WIDTH-1:0] opcode,
    input  logic                    branch_taken,
    input  logic                    mem_ready,
    output logic                    mem_req,
    output logic                    mem_we,
    output logic                    iord,
    output logic                    ir_write,
    output logic                    pc_write,
    output logic [1:0]              pc_src,
    output logic                    alusrc,
    output logic [ALUOP_WIDTH-1:0]  aluop,
    output logic                    reg_write,
    output logic [1:0]              wb_sel,
    output logic [2:0]              state,
    output logic                    bus_timeout,
    output logic                    illegal_insn
);

    state_e     state_q;
    state_e     state_d;
    logic [4:0] op_q;
    logic [4:0] op_d;
    logic       bus_timeout_q;
    logic       timeout_set;
    logic [1:0] aluop_w;
    logic       wait_w;
    logic       clear_w;
    logic       expired_w;
    logic       legal_w;
`ifdef CTRL_ILLEGAL_TRAP_EN
    logic       illegal_q;
    logic       illegal_set;
`endif

    assign legal_w = is_legal_op(opcode[6:0]);

    // Only FETCH and MEM wait on memory; any state change restarts the count.
    assign wait_w  = ((state_q == ST_FETCH) || (state_q == ST_MEM)) && !mem_ready;
    assign clear_w = (state_d != state_q);

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT),
        .CNT_WIDTH   (CNT_WIDTH)
    ) u_mem_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .clear_i   (clear_w),
        .wait_i    (wait_w),
        .expired_o (expired_w)
    );

    // Next-state and strobe decode; every output defaults to inactive.
    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        timeout_set = 1'b0;
`ifdef CTRL_ILLEGAL_TRAP_EN
        illegal_set = 1'b0;
`endif
        mem_req     = 1'b0;
        mem_we      = 1'b0;
        iord        = 1'b0;
        ir_write    = 1'b0;
        pc_write    = 1'b0;
        pc_src      = PC_SRC_PLUS4;
        alusrc      = 1'b0;
        aluop_w     = ALUOP_ADD;
        reg_write   = 1'b0;
        wb_sel      = WB_SEL_ALU;

        case (state_q)
            ST_IDLE: begin
                state_d = ST_FETCH;
            end

            ST_FETCH: begin
                mem_req = 1'b1;
                iord    = 1'b0;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    pc_src   = PC_SRC_PLUS4;
                    state_d  = ST_DECODE;
                end else if (expired_w) begin
                    timeout_set = 1'b1;
                    state_d     = ST_HALT;
                end
            end

            ST_DECODE: begin
                op_d = opcode[6:2];
                if (legal_w) begin
                    state_d = ST_EXEC;
                end else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
                    illegal_set = 1'b1;
                    state_d     = ST_HALT;
`else
                    state_d     = ST_FETCH;
`endif
                end
            end

            ST_EXEC: begin
                state_d = ST_WB;
                case (op_q)
                    OP_REG: begin
                        aluop_w = ALUOP_RFUNCT;
                    end
                    OP_IMMOP: begin
                        aluop_w = ALUOP_IFUNCT;
                        alusrc  = 1'b1;
                    end
                    OP_LOAD, OP_STORE: begin
                        alusrc  = 1'b1;
                        state_d = ST_MEM;
                    end
                    OP_AUIPC: begin
                        alusrc = 1'b1;
                    end
                    OP_BRANCH: begin
                        aluop_w  = ALUOP_BRANCH;
                        pc_write = branch_taken;
                        pc_src   = PC_SRC_TARGET;
                        state_d  = ST_FETCH;
                    end
                    OP_JAL: begin
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_TARGET;
                    end
                    OP_JALR: begin
                        alusrc   = 1'b1;
                        pc_write = 1'b1;
                        pc_src   = PC_SRC_JALR;
                    end
                    default: begin
                        // LUI: the immediate goes straight to writeback.
                    end
                endcase
            end

            ST_MEM: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                mem_we  = (op_q == OP_STORE);
                if (mem_ready) begin
                    state_d = (op_q == OP_STORE) ? ST_FETCH : ST_WB;
                end else if (expired_w) begin
                    timeout_set = 1'b1;
                    state_d     = ST_HALT;
                end
            end

            ST_WB: begin
                reg_write = 1'b1;
                case (op_q)
                    OP_LOAD:         wb_sel = WB_SEL_MEM;
                    OP_JAL, OP_JALR: wb_sel = WB_SEL_PC4;
                    OP_LUI:          wb_sel = WB_SEL_IMM;
                    default:         wb_sel = WB_SEL_ALU;
                endcase
                state_d = ST_FETCH;
            end

            ST_HALT: begin
                state_d = ST_HALT;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, latched opcode class and sticky timeout flag.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q       <= ST_IDLE;
            op_q          <= '0;
            bus_timeout_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            op_q          <= op_d;
            bus_timeout_q <= bus_timeout_q | timeout_set;
        end
    end

`ifdef CTRL_ILLEGAL_TRAP_EN
    // Sticky illegal-opcode flag, cleared only by reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            illegal_q <= 1'b0;
        end else begin
            illegal_q <= illegal_q | illegal_set;
        end
    end

    assign illegal_insn = illegal_q;
`else
    assign illegal_insn = 1'b0;
`endif

    assign aluop       = ALUOP_WIDTH'(aluop_w);
    assign state       = state_q;
    assign bus_timeout = bus_timeout_q;

endmodule

`default_nettype wire
